// File: rtl/parking_pkg.sv
// Shared constants for the smart-parking exit path.
// Holds the slot count, slot index width, default timer/fee widths and
// pricing, the FSM state encoding, and a helper that counts free slots.
package parking_pkg;

    localparam int N_SLOTS      = 8;
    localparam int SLOT_W       = 3;
    localparam int CNT_W        = 4;
    localparam int TIMER_W_DEF  = 8;
    localparam int FEE_W_DEF    = 16;
    localparam int BASE_FEE_DEF = 10;
    localparam int RATE_DEF     = 5;

    // Exit FSM encoding: one state per cycle, IDLE->CHECK->BILL->RESP->IDLE
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_BILL  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Number of zero bits in an occupancy vector
    function automatic logic [CNT_W-1:0] count_free(input logic [N_SLOTS-1:0] occ);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!occ[i]) n = n + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot dwell timer.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset, clears the count
//   clear  - restart the count at zero; wins over tick
//   tick   - advance by one (caller gates this with slot occupancy)
//   count  - current dwell time in ticks, saturating at all ones
module slot_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parking_exit_controller.sv
// Exit controller for the smart-parking system.
// Owns the occupancy register, accepts entries from the entry path, runs a
// dwell timer per slot and services exit requests with a four-cycle
// IDLE->CHECK->BILL->RESP handshake that returns a fee or an empty-slot error.
// Ports:
//   clk, reset        - system clock; synchronous active-high reset
//   tick              - time-base pulse advancing timers of occupied slots
//   entry_valid       - park_location is valid this cycle
//   park_location     - slots being entered (multi-hot allowed)
//   exit_valid        - exit request, held by the requester until accepted
//   exit_ready        - high in IDLE only
//   exit_slot         - index of the departing slot
//   fee_valid         - one-cycle pulse qualifying fee and exit_error
//   fee               - amount due, zero outside RESP or on error
//   exit_error        - requested slot was empty
//   entry_error       - pulse: an entry hit an already occupied slot
//   parking_capacity  - occupancy register, 1 = occupied
//   free_count        - number of free slots
//   full              - every slot occupied
module parking_exit_controller
    import parking_pkg::*;
#(
    parameter int TIMER_W  = TIMER_W_DEF,
    parameter int FEE_W    = FEE_W_DEF,
    parameter int BASE_FEE = BASE_FEE_DEF,
    parameter int RATE     = RATE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               entry_valid,
    input  logic [N_SLOTS-1:0] park_location,
    input  logic               exit_valid,
    output logic               exit_ready,
    input  logic [SLOT_W-1:0]  exit_slot,
    output logic               fee_valid,
    output logic [FEE_W-1:0]   fee,
    output logic               exit_error,
    output logic               entry_error,
    output logic [N_SLOTS-1:0] parking_capacity,
    output logic [CNT_W-1:0]   free_count,
    output logic               full
);

    localparam int PW = TIMER_W + FEE_W;

    logic [1:0]         state;
    logic [N_SLOTS-1:0] occupancy;
    logic [N_SLOTS-1:0] entry_set;
    logic [N_SLOTS-1:0] entry_hit;
    logic [N_SLOTS-1:0] exit_clear;
    logic [N_SLOTS-1:0] timer_clear;
    logic [TIMER_W-1:0] timer_val [N_SLOTS];
    logic [SLOT_W-1:0]  slot_q;
    logic               occ_hit;
    logic [TIMER_W-1:0] timer_q;
    logic [FEE_W-1:0]   fee_r;
    logic               err_r;
    logic               entry_error_r;
    logic [PW-1:0]      product;
    logic [PW:0]        fee_sum;
    logic [FEE_W-1:0]   fee_calc;

    // Entries only land on free slots; hits on occupied slots are flagged.
    // The slot under BILL is still occupied here, so a same-cycle entry on
    // it is rejected while the exit clears it.
    always_comb begin
        entry_set  = entry_valid ? (park_location & ~occupancy) : '0;
        entry_hit  = entry_valid ? (park_location & occupancy) : '0;
        exit_clear = '0;
        if ((state == ST_BILL) && occ_hit) exit_clear[slot_q] = 1'b1;
        timer_clear = entry_set | exit_clear;
    end

    // Fee = BASE_FEE + timer*RATE computed wide enough never to wrap,
    // then clamped to the output width.
    always_comb begin
        product  = PW'(timer_q) * PW'(RATE);
        fee_sum  = {1'b0, product} + (PW+1)'(BASE_FEE);
        fee_calc = (|fee_sum[PW:FEE_W]) ? '1 : fee_sum[FEE_W-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_timer
            slot_timer #(.W(TIMER_W)) u_timer (
                .clk   (clk),
                .reset (reset),
                .clear (timer_clear[gi]),
                .tick  (tick & occupancy[gi]),
                .count (timer_val[gi])
            );
        end
    endgenerate

    // Occupancy register and the registered entry-collision pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy     <= '0;
            entry_error_r <= 1'b0;
        end else begin
            occupancy     <= (occupancy | entry_set) & ~exit_clear;
            entry_error_r <= |entry_hit;
        end
    end

    // Exit FSM: latch slot, sample occupancy/timer, bill, respond
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            slot_q  <= '0;
            occ_hit <= 1'b0;
            timer_q <= '0;
            fee_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exit_valid) begin
                        slot_q <= exit_slot;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    occ_hit <= occupancy[slot_q];
                    timer_q <= timer_val[slot_q];
                    state   <= ST_BILL;
                end
                ST_BILL: begin
                    if (occ_hit) begin
                        fee_r <= fee_calc;
                        err_r <= 1'b0;
                    end else begin
                        fee_r <= '0;
                        err_r <= 1'b1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign exit_ready       = (state == ST_IDLE);
    assign fee_valid        = (state == ST_RESP);
    assign fee              = (state == ST_RESP) ? fee_r : '0;
    assign exit_error       = (state == ST_RESP) ? err_r : 1'b0;
    assign entry_error      = entry_error_r;
    assign parking_capacity = occupancy;
    assign free_count       = count_free(occupancy);
    assign full             = &occupancy;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed bench for parking_exit_controller. A second instance with
// RATE=300 shares all inputs so fee saturation is observed on the same run.
module tb_parking_exit_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        entry_valid;
    logic [7:0]  park_location;
    logic        exit_valid;
    logic [2:0]  exit_slot;

    logic        exit_ready, fee_valid, exit_error, entry_error, full;
    logic [15:0] fee;
    logic [7:0]  parking_capacity;
    logic [3:0]  free_count;

    logic        hi_exit_ready, hi_fee_valid, hi_exit_error, hi_entry_error, hi_full;
    logic [15:0] hi_fee;
    logic [7:0]  hi_capacity;
    logic [3:0]  hi_free_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parking_exit_controller dut (
        .clk(clk), .reset(reset), .tick(tick),
        .entry_valid(entry_valid), .park_location(park_location),
        .exit_valid(exit_valid), .exit_ready(exit_ready), .exit_slot(exit_slot),
        .fee_valid(fee_valid), .fee(fee), .exit_error(exit_error),
        .entry_error(entry_error), .parking_capacity(parking_capacity),
        .free_count(free_count), .full(full)
    );

    parking_exit_controller #(.RATE(300)) dut_hi (
        .clk(clk), .reset(reset), .tick(tick),
        .entry_valid(entry_valid), .park_location(park_location),
        .exit_valid(exit_valid), .exit_ready(hi_exit_ready), .exit_slot(exit_slot),
        .fee_valid(hi_fee_valid), .fee(hi_fee), .exit_error(hi_exit_error),
        .entry_error(hi_entry_error), .parking_capacity(hi_capacity),
        .free_count(hi_free_count), .full(hi_full)
    );

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] loc);
        entry_valid   = 1'b1;
        park_location = loc;
        step();
        entry_valid   = 1'b0;
        park_location = '0;
    endtask

    task automatic apply_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // Handshake in cycle c, response expected in cycle c+3
    task automatic run_exit(input string tag, input logic [2:0] slot,
                            input logic [15:0] exp_fee, input logic [15:0] exp_fee_hi,
                            input logic exp_err, input logic [7:0] exp_cap);
        check_output({tag, " ready"}, exit_ready, 1'b1);
        exit_valid = 1'b1;
        exit_slot  = slot;
        step();
        exit_valid = 1'b0;
        check_output({tag, " busy"}, exit_ready, 1'b0);
        step();
        check_output({tag, " early"}, fee_valid, 1'b0);
        step();
        check_output({tag, " fee_valid"}, fee_valid, 1'b1);
        check_output({tag, " fee"}, fee, exp_fee);
        check_output({tag, " fee_hi"}, hi_fee, exp_fee_hi);
        check_output({tag, " exit_error"}, exit_error, exp_err);
        check_output({tag, " capacity"}, parking_capacity, exp_cap);
        step();
        check_output({tag, " fee_after"}, fee, 16'd0);
        check_output({tag, " idle"}, exit_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; entry_valid = 1'b0; park_location = '0;
        exit_valid = 1'b0; exit_slot = '0;
        repeat (2) step();

        // Reset state
        check_output("rst capacity", parking_capacity, 8'h00);
        check_output("rst free_count", free_count, 4'd8);
        check_output("rst full", full, 1'b0);
        check_output("rst exit_ready", exit_ready, 1'b1);
        check_output("rst fee_valid", fee_valid, 1'b0);
        check_output("rst fee", fee, 16'd0);
        check_output("rst entry_error", entry_error, 1'b0);
        reset = 1'b0;
        step();

        // Slot 2 for 4 ticks: 10 + 4*5 = 30 (hi: 10 + 4*300 = 1210)
        apply_stimulus(8'h04);
        check_output("entry capacity", parking_capacity, 8'h04);
        check_output("entry free_count", free_count, 4'd7);
        check_output("entry no error", entry_error, 1'b0);
        apply_ticks(4);
        run_exit("exit2", 3'd2, 16'd30, 16'd1210, 1'b0, 8'h00);

        // Empty slot 5
        run_exit("empty5", 3'd5, 16'd0, 16'd0, 1'b1, 8'h00);

        // Slot 0 for 300 ticks: timer saturates at 255 -> 1285; hi saturates at 65535
        apply_stimulus(8'h01);
        apply_ticks(300);
        run_exit("sat0", 3'd0, 16'd1285, 16'hFFFF, 1'b0, 8'h00);

        // Entry on slot 2 during its BILL cycle is rejected; exit clears it
        apply_stimulus(8'h04);
        exit_valid = 1'b1; exit_slot = 3'd2;
        step();
        exit_valid = 1'b0;
        step();
        entry_valid = 1'b1; park_location = 8'h04;
        step();
        entry_valid = 1'b0; park_location = '0;
        check_output("bill entry_error", entry_error, 1'b1);
        check_output("bill fee_valid", fee_valid, 1'b1);
        check_output("bill fee", fee, 16'd10);
        check_output("bill capacity", parking_capacity, 8'h00);
        step();
        check_output("bill entry_error pulse", entry_error, 1'b0);

        // Multi-hot entry 8'hFF with slot 1 occupied
        apply_stimulus(8'h02);
        apply_stimulus(8'hFF);
        check_output("ff entry_error", entry_error, 1'b1);
        check_output("ff capacity", parking_capacity, 8'hFF);
        check_output("ff full", full, 1'b1);
        check_output("ff free_count", free_count, 4'd0);
        step();
        check_output("ff entry_error pulse", entry_error, 1'b0);

        // Reset during BILL drops the transaction
        exit_valid = 1'b1; exit_slot = 3'd3;
        step();
        exit_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output("midrst fee_valid", fee_valid, 1'b0);
        check_output("midrst capacity", parking_capacity, 8'h00);
        check_output("midrst exit_ready", exit_ready, 1'b1);
        step();
        check_output("midrst no late fee", fee_valid, 1'b0);

        // exit_valid held while busy: second request accepted only after RESP
        apply_stimulus(8'h08);
        exit_valid = 1'b1; exit_slot = 3'd3;
        step();
        check_output("hold busy1", exit_ready, 1'b0);
        step();
        step();
        check_output("hold resp1 valid", fee_valid, 1'b1);
        check_output("hold resp1 fee", fee, 16'd10);
        step();
        check_output("hold accept", exit_ready, 1'b1);
        step();
        exit_valid = 1'b0;
        check_output("hold busy2", exit_ready, 1'b0);
        step();
        check_output("hold not yet", fee_valid, 1'b0);
        step();
        check_output("hold resp2 valid", fee_valid, 1'b1);
        check_output("hold resp2 error", exit_error, 1'b1);
        check_output("hold resp2 fee", fee, 16'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
